// File: rtl/ele_run_ctrl.sv
// Elevator run controller for a 4-storey car.
// Consumes the pending-request vector and up/down demand from the request
// processor. Moves the car one floor per FLOOR_TICKS clocks, dwells the door
// for DOOR_TICKS clocks, and reports position, run mode, door and arrival.
// Optional feature: define EMERG_STOP_EN to add the estop input (freeze).
// Ports:
//   clk, rst_n            32 Hz clock, async active-low reset
//   allReq_reg[3:0]       pending requests, one-hot per floor (bit0 = floor 1)
//   up_need, down_need    directional demand from the request processor
//   open_btn, close_btn   in-car door buttons (level)
//   estop                 emergency stop, level (EMERG_STOP_EN only)
//   position[3:0]         car floor, one-hot
//   floor_num[1:0]        car floor, binary
//   ud_mode[1:0]          00 stop, 01 up, 10 down
//   door_open             door open
//   arrive                one-cycle pulse on entering a new floor
module ele_run_ctrl #(
    parameter int unsigned FLOOR_TICKS = 64,
    parameter int unsigned DOOR_TICKS  = 96,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] allReq_reg,
    input  logic       up_need,
    input  logic       down_need,
    input  logic       open_btn,
    input  logic       close_btn,
`ifdef EMERG_STOP_EN
    input  logic       estop,
`endif
    output logic [3:0] position,
    output logic [1:0] floor_num,
    output logic [1:0] ud_mode,
    output logic       door_open,
    output logic       arrive
);

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;
    localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_ARRIVE, S_DOOR_OPEN, S_DECIDE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;   // working direction, survives estop
    logic [1:0]       floor_d;
    logic             door_d, arrive_d;
    logic             halt;

`ifdef EMERG_STOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    // Request geometry relative to the car
    logic [3:0] above_mask, below_mask;
    logic       here, above, below, dir_up, fwd, rev;
    logic       floor_end, door_end;

    assign above_mask = 4'(4'b1110 << floor_num);
    assign below_mask = ~(4'(4'b1111 << floor_num));
    assign here       = |(allReq_reg & position);
    assign above      = |(allReq_reg & above_mask);
    assign below      = |(allReq_reg & below_mask);
    assign dir_up     = (mode_q == UD_UP);
    assign fwd        = dir_up ? above : below;
    assign rev        = dir_up ? below : above;
    assign floor_end  = (cnt_q == FLOOR_LAST);
    assign door_end   = (cnt_q == DOOR_LAST);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= UD_STOP;
            floor_num <= 2'd0;
            position  <= 4'b0001;
            ud_mode   <= UD_STOP;
            door_open <= 1'b0;
            arrive    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            floor_num <= floor_d;
            position  <= 4'(4'b0001 << floor_d);
            ud_mode   <= halt ? UD_STOP : mode_d;
            door_open <= door_d;
            arrive    <= arrive_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!halt) begin
            unique case (state_q)
                S_IDLE: begin
                    if (here)                    state_d = S_DOOR_OPEN;
                    else if (up_need && above)   state_d = S_MOVE_UP;
                    else if (down_need && below) state_d = S_MOVE_DOWN;
                end
                S_MOVE_UP: begin
                    if (floor_num == 2'd3) state_d = S_IDLE;
                    else if (floor_end)    state_d = S_ARRIVE;
                end
                S_MOVE_DOWN: begin
                    if (floor_num == 2'd0) state_d = S_IDLE;
                    else if (floor_end)    state_d = S_ARRIVE;
                end
                S_ARRIVE: begin
                    if (here)     state_d = S_DOOR_OPEN;
                    else if (fwd) state_d = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                    else          state_d = S_DECIDE;
                end
                S_DOOR_OPEN: begin
                    if (!open_btn && (close_btn || door_end)) state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    if (fwd)       state_d = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                    else if (rev)  state_d = dir_up ? S_MOVE_DOWN : S_MOVE_UP;
                    else if (here) state_d = S_DOOR_OPEN;
                    else           state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of counter, direction and registered outputs
    always_comb begin
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        floor_d  = floor_num;
        door_d   = door_open;
        arrive_d = 1'b0;
        if (!halt) begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    door_d = 1'b0;
                    if (here) begin
                        // Non-stop mode lets the request processor clear this floor
                        mode_d = (floor_num == 2'd3) ? UD_DOWN : UD_UP;
                        door_d = 1'b1;
                    end else if (up_need && above)   mode_d = UD_UP;
                    else if (down_need && below)     mode_d = UD_DOWN;
                    else                             mode_d = UD_STOP;
                end
                S_MOVE_UP, S_MOVE_DOWN: begin
                    if ((state_q == S_MOVE_UP   && floor_num == 2'd3) ||
                        (state_q == S_MOVE_DOWN && floor_num == 2'd0)) begin
                        mode_d = UD_STOP;
                        cnt_d  = '0;
                    end else if (floor_end) begin
                        cnt_d    = '0;
                        floor_d  = (state_q == S_MOVE_UP) ? floor_num + 2'd1
                                                          : floor_num - 2'd1;
                        arrive_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ARRIVE: begin
                    cnt_d = '0;
                    if (here) door_d = 1'b1;
                    // Pass-through: the ARRIVE cycle counts as the first travel tick
                    else if (fwd) cnt_d = CNT_W'(1);
                end
                S_DOOR_OPEN: begin
                    if (open_btn) begin
                        cnt_d = '0;
                    end else if (close_btn || door_end) begin
                        cnt_d  = '0;
                        door_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DECIDE: begin
                    cnt_d = '0;
                    if (fwd)       mode_d = mode_q;
                    else if (rev)  mode_d = dir_up ? UD_DOWN : UD_UP;
                    else if (here) door_d = 1'b1;
                    else           mode_d = UD_STOP;
                end
                default: begin
                    cnt_d  = '0;
                    mode_d = UD_STOP;
                    door_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ele_run_ctrl.sv
// Directed bench for ele_run_ctrl with hand-computed cycle expectations.
module tb_ele_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] allReq_reg;
    logic       up_need, down_need, open_btn, close_btn;
    logic       estop;
    logic [3:0] position;
    logic [1:0] floor_num, ud_mode;
    logic       door_open, arrive;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ele_run_ctrl #(.FLOOR_TICKS(64), .DOOR_TICKS(96), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .allReq_reg (allReq_reg),
        .up_need    (up_need),
        .down_need  (down_need),
        .open_btn   (open_btn),
        .close_btn  (close_btn),
`ifdef EMERG_STOP_EN
        .estop      (estop),
`endif
        .position   (position),
        .floor_num  (floor_num),
        .ud_mode    (ud_mode),
        .door_open  (door_open),
        .arrive     (arrive)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n cycles; outputs are then sampled at the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        allReq_reg = 4'b0000;
        up_need = 1'b0; down_need = 1'b0;
        open_btn = 1'b0; close_btn = 1'b0; estop = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_pos",   position,  4'b0001);
        chk("rst_floor", {2'b00, floor_num}, 4'd0);
        chk("rst_ud",    {2'b00, ud_mode},   4'd0);
        chk("rst_door",  {3'b000, door_open}, 4'd0);
        chk("rst_arr",   {3'b000, arrive},    4'd0);

        // 1: travel floor 1 -> floor 3 (bit2), door dwell, then idle
        allReq_reg = 4'b0100; up_need = 1'b1;
        cyc(1);
        chk("t1_ud_up",  {2'b00, ud_mode}, 4'b0001);
        chk("t1_pos0",   position, 4'b0001);
        cyc(63);
        chk("t1_pre1",   position, 4'b0001);
        cyc(1);
        chk("t1_pos1",   position, 4'b0010);
        chk("t1_arr1",   {3'b000, arrive}, 4'd1);
        cyc(1);
        chk("t1_arr1_off", {3'b000, arrive}, 4'd0);
        cyc(62);
        chk("t1_pre2",   position, 4'b0010);
        cyc(1);
        chk("t1_pos2",   position, 4'b0100);
        chk("t1_floor2", {2'b00, floor_num}, 4'd2);
        chk("t1_arr2",   {3'b000, arrive}, 4'd1);
        cyc(1);
        chk("t1_door",   {3'b000, door_open}, 4'd1);
        chk("t1_ud_held", {2'b00, ud_mode}, 4'b0001);
        allReq_reg = 4'b0000; up_need = 1'b0;
        cyc(95);
        chk("t1_door_last", {3'b000, door_open}, 4'd1);
        cyc(1);
        chk("t1_door_shut", {3'b000, door_open}, 4'd0);
        cyc(1);
        chk("t1_idle_ud", {2'b00, ud_mode}, 4'b0000);

        // 2: request at the current floor opens the door in up mode
        do_reset();
        allReq_reg = 4'b0001;
        cyc(1);
        chk("t2_door",   {3'b000, door_open}, 4'd1);
        chk("t2_ud",     {2'b00, ud_mode}, 4'b0001);
        allReq_reg = 4'b0000;
        cyc(95);
        chk("t2_door_last", {3'b000, door_open}, 4'd1);
        cyc(1);
        chk("t2_door_shut", {3'b000, door_open}, 4'd0);
        cyc(1);
        chk("t2_idle_ud", {2'b00, ud_mode}, 4'b0000);

        // 3: open_btn (priority over close_btn) extends dwell; close_btn ends it
        allReq_reg = 4'b0001;
        cyc(1);
        allReq_reg = 4'b0000;
        open_btn = 1'b1; close_btn = 1'b1;
        cyc(120);
        chk("t3_held_open", {3'b000, door_open}, 4'd1);
        open_btn = 1'b0; close_btn = 1'b0;
        cyc(40);
        chk("t3_restarted", {3'b000, door_open}, 4'd1);
        close_btn = 1'b1;
        cyc(1);
        chk("t3_closed", {3'b000, door_open}, 4'd0);
        close_btn = 1'b0;
        cyc(1);
        chk("t3_idle_ud", {2'b00, ud_mode}, 4'b0000);

        // 4: go up to bit2 with a bit0 request posted en route, then reverse
        do_reset();
        allReq_reg = 4'b0100; up_need = 1'b1;
        cyc(10);
        allReq_reg = 4'b0101; down_need = 1'b1;
        cyc(55);
        chk("t4_pass1", position, 4'b0010);
        cyc(64);
        chk("t4_at2",   position, 4'b0100);
        cyc(1);
        chk("t4_door",  {3'b000, door_open}, 4'd1);
        allReq_reg = 4'b0001; up_need = 1'b0;
        cyc(96);
        chk("t4_shut",  {3'b000, door_open}, 4'd0);
        chk("t4_ud_pre", {2'b00, ud_mode}, 4'b0001);
        cyc(1);
        chk("t4_rev",   {2'b00, ud_mode}, 4'b0010);
        cyc(127);
        chk("t4_pre0",  position, 4'b0010);
        cyc(1);
        chk("t4_at0",   position, 4'b0001);
        chk("t4_arr0",  {3'b000, arrive}, 4'd1);
        cyc(1);
        chk("t4_door0", {3'b000, door_open}, 4'd1);

        // 5: reset mid-travel at count 30 between floors 2 and 3
        do_reset();
        allReq_reg = 4'b0100; up_need = 1'b1;
        cyc(95);
        chk("t5_mid_floor", {2'b00, floor_num}, 4'd1);
        chk("t5_mid_ud",    {2'b00, ud_mode}, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t5_pos",   position, 4'b0001);
        chk("t5_ud",    {2'b00, ud_mode}, 4'b0000);
        chk("t5_arr",   {3'b000, arrive}, 4'd0);
        chk("t5_floor", {2'b00, floor_num}, 4'd0);
        do_reset();

`ifdef EMERG_STOP_EN
        // 6: estop at count 20 for 40 cycles, then resume from the frozen count
        allReq_reg = 4'b0010; up_need = 1'b1;
        cyc(21);
        estop = 1'b1;
        cyc(1);
        chk("t6_stop_ud", {2'b00, ud_mode}, 4'b0000);
        cyc(39);
        chk("t6_hold_ud",  {2'b00, ud_mode}, 4'b0000);
        chk("t6_hold_pos", position, 4'b0001);
        estop = 1'b0;
        cyc(1);
        chk("t6_resume_ud", {2'b00, ud_mode}, 4'b0001);
        cyc(42);
        chk("t6_pre", position, 4'b0001);
        cyc(1);
        chk("t6_pos", position, 4'b0010);
        chk("t6_arr", {3'b000, arrive}, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
